// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam int WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter with zero flag; it holds at zero instead of wrapping.
module arb_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux2_32.sv
// 32-bit 2:1 mux: sel=0 passes in0, sel=1 passes in1.
module mux2_32 (
    input  logic        sel,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic [31:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (IF / data) arbiter for the unified memory port with a fixed-wait access.
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break instead of data-first priority.
//
// state  | meaning
// IDLE   | sample requests, pick winner, latch address/data/we
// ACCESS | mem_en high for WAIT_CYCLES cycles; capture read data on the last one
// RESP   | one-cycle ready pulse to the winner, rdata valid
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mux_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] rdata,
    output logic        if_ready,
    output logic        dm_ready,
    output logic        if_stall,
    output logic        dm_stall
);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        win;
    logic        we_lat;
    logic        grant_port;
    logic        tie_port;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;
    logic        capture;
    logic        sel_int;
    logic [31:0] mux_addr;
    logic [31:0] mux_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr;   // port favoured on the next tie

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= PORT_IF;
        end else if (cnt_load) begin
            rr_ptr <= ~grant_port;
        end
    end

    assign tie_port = rr_ptr;
`else
    assign tie_port = PORT_DM;
`endif

    always_comb begin
        grant_port = PORT_IF;
        if (if_req && dm_req) begin
            grant_port = tie_port;
        end else if (dm_req) begin
            grant_port = PORT_DM;
        end
    end

    // win is only updated on leaving IDLE, so in IDLE the mux must follow the
    // fresh arbitration result for the latch to see the winner's address.
    assign sel_int = (state == IDLE) ? grant_port : win;
    assign mux_sel = win;

    mux2_32 u_addr_mux (
        .sel (sel_int),
        .in0 (if_addr),
        .in1 (dm_addr),
        .y   (mux_addr)
    );

    mux2_32 u_wdata_mux (
        .sel (sel_int),
        .in0 (32'h0),
        .in1 (dm_wdata),
        .y   (mux_wdata)
    );

    arb_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(WAIT_CYCLES - 1)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        capture   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    cnt_load  = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en  = 1'b1;
                mem_we  = we_lat;
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win       <= PORT_IF;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_lat    <= 1'b0;
            rdata     <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if (cnt_load) begin
                win       <= grant_port;
                mem_addr  <= mux_addr;
                mem_wdata <= mux_wdata;
                we_lat    <= (grant_port == PORT_DM) && dm_we;
            end
            if (capture) begin
                rdata    <= mem_rdata;
                if_ready <= (win == PORT_IF);
                dm_ready <= (win == PORT_DM);
            end
        end
    end

    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, monitor checks accesses and responses.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mux_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] rdata;
    logic        if_ready;
    logic        dm_ready;
    logic        if_stall;
    logic        dm_stall;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .mem_rdata (mem_rdata),
        .mux_sel   (mux_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .rdata     (rdata),
        .if_ready  (if_ready),
        .dm_ready  (dm_ready),
        .if_stall  (if_stall),
        .dm_stall  (dm_stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        chk_rd;
        int          exp_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic rr_fav = PORT_IF;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hE3A0_1005;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~if_ready});
            check("dm_stall", {31'b0, dm_stall}, {31'b0, dm_req & ~dm_ready});
            check("ready_exclusive", {31'b0, if_ready & dm_ready}, 32'h0);
            if (mem_en) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_access: mem_en=1 with nothing pending (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q[0];
                    check("mux_sel", {31'b0, mux_sel}, {31'b0, mon_e.port});
                    check("mem_addr", mem_addr, mon_e.addr);
                    check("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
                    if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.wdata);
                end
            end
            if (if_ready || dm_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: if_ready=%0b dm_ready=%0b (cycle %0d)", if_ready, dm_ready, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ready_port", {31'b0, dm_ready}, {31'b0, mon_e.port});
                    check("ready_cycle", cyc, mon_e.exp_cyc);
                    if (mon_e.chk_rd) check("rdata", rdata, mon_e.rdata);
                end
            end
        end
    end

    task automatic push(input logic port, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata, input int exp_cyc);
        exp_t e;
        e.port    = port;
        e.addr    = addr;
        e.we      = we;
        e.wdata   = wdata;
        e.rdata   = mem_model(addr);
        e.chk_rd  = !we;
        e.exp_cyc = exp_cyc;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic port, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        if (port == PORT_IF) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            dm_req   = 1'b1;
            dm_addr  = addr;
            dm_we    = we;
            dm_wdata = wdata;
        end
    endtask

    task automatic wait_drop(input logic port);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = (port == PORT_IF) ? if_ready : dm_ready;
        end
        check(port == PORT_IF ? "if_ready_seen" : "dm_ready_seen", {31'b0, seen}, 32'h1);
        @(posedge clk);
        #1;
        if (port == PORT_IF) if_req = 1'b0;
        else                 dm_req = 1'b0;
    endtask

    // Called at #1 after a clock edge while the arbiter is in IDLE.
    task automatic single(input logic port, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        push(port, addr, (port == PORT_DM) && we, wdata, cyc + 3);
        drive(port, addr, we, wdata);
        wait_drop(port);
        rr_fav = ~port;
    endtask

    task automatic tie(input logic [31:0] a_if, input logic [31:0] a_dm);
        logic first;
        int   c;
        first = RR ? rr_fav : PORT_DM;
        c = cyc;
        push(first, first ? a_dm : a_if, 1'b0, 32'h0, c + 3);
        push(~first, first ? a_if : a_dm, 1'b0, 32'h0, c + 7);
        drive(PORT_IF, a_if, 1'b0, 32'h0);
        drive(PORT_DM, a_dm, 1'b0, 32'h0);
        fork
            wait_drop(PORT_IF);
            wait_drop(PORT_DM);
        join
        rr_fav = first;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic first;
        int   c;

        // Reset with both requests pending.
        if_req  = 1'b1;
        if_addr = 32'h0000_010C;
        dm_req  = 1'b1;
        dm_addr = 32'h0000_040C;
        dm_we   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mux_sel", {31'b0, mux_sel}, 32'h0);
        check("rst_ready", {30'b0, if_ready, dm_ready}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        rr_fav = PORT_IF;
        first = RR ? rr_fav : PORT_DM;
        c = cyc;
        push(first, first ? 32'h0000_040C : 32'h0000_010C, 1'b0, 32'h0, c + 3);
        push(~first, first ? 32'h0000_010C : 32'h0000_040C, 1'b0, 32'h0, c + 7);
        @(posedge clk);
        #1;
        check("first_mem_en", {31'b0, mem_en}, 32'h1);
        fork
            wait_drop(PORT_IF);
            wait_drop(PORT_DM);
        join
        rr_fav = first;

        single(PORT_IF, 32'h0000_0100, 1'b0, 32'h0);
        single(PORT_DM, 32'h0000_0400, 1'b1, 32'hDEAD_BEEF);
        tie(32'h0000_0104, 32'h0000_0408);
        for (int k = 0; k < 4; k++) begin
            tie(32'h0000_0120 + 32'(k * 4), 32'h0000_0500 + 32'(k * 4));
        end
        single(PORT_IF, 32'h0000_0110, 1'b0, 32'h0);
        single(PORT_IF, 32'h0000_0114, 1'b0, 32'h0);

        // Reset during the second ACCESS cycle; the held request reruns after release.
        c = cyc;
        push(PORT_IF, 32'h0000_0200, 1'b0, 32'h0, c + 6);
        drive(PORT_IF, 32'h0000_0200, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_mem_en", {31'b0, mem_en}, 32'h0);
        check("midrst_if_ready", {31'b0, if_ready}, 32'h0);
        wait_drop(PORT_IF);
        rr_fav = PORT_DM;

        single(PORT_DM, 32'h0000_0410, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit unified memory port between two requesters: instruction fetch (IF, port 0) and data load/store (MEM stage, port 1).
- Owns the select line of the 2:1 32-bit address/write-data mux in front of memory and sequences a fixed-wait-state access.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Drives per-port stall signals consumed by the pipeline freeze logic.

Parameters:
- WAIT_CYCLES, 2, memory access length in cycles; legal range 1..15.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch address
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- mem_rdata  in  32  memory read data, valid in the last ACCESS cycle
- mux_sel  out  1  address/wdata mux select: 0 = IF, 1 = data
- mem_addr  out  32  latched address of the access in flight
- mem_wdata  out  32  latched store data
- mem_en  out  1  access strobe
- mem_we  out  1  write strobe
- rdata  out  32  registered read data to the winner
- if_ready  out  1  one-cycle completion pulse, port 0
- dm_ready  out  1  one-cycle completion pulse, port 1
- if_stall  out  1  if_req & ~if_ready
- dm_stall  out  1  dm_req & ~dm_ready

Behaviour:
- FSM states: IDLE, ACCESS, RESP. A 1-bit registered winner `win` drives mux_sel.
- Reset: on rst high at a clock edge, all of the following go to 0: state=IDLE, win, mem_addr, mem_wdata, mem_en, mem_we, rdata, if_ready, dm_ready, counter, and the round-robin pointer.
- Reset mid-operation:
  - The access is abandoned and no ready is issued.
  - Requesters keep req high and the access is re-arbitrated after reset.
- IDLE:
  - Requests are sampled only in IDLE.
  - If neither req is high, stay in IDLE with mem_en=0.
  - Otherwise pick a winner per the priority rule.
  - Latch win, address, wdata and we (we forced to 0 for IF).
  - Load counter=WAIT_CYCLES-1 and go to ACCESS.
- ACCESS:
  - mem_en=1, and mem_we equals the latched we.
  - Counter decrements each cycle.
  - When counter==0, capture mem_rdata into rdata (stores capture it too; the value is don't-care) and go to RESP.
  - ACCESS lasts exactly WAIT_CYCLES cycles.
- RESP:
  - mem_en=0 and mem_we=0.
  - Assert the winner's ready for exactly one cycle; rdata is valid in that cycle and held until the next capture.
  - Next state is IDLE.
- Latency: a req sampled in IDLE at cycle t gives ready at cycle t+WAIT_CYCLES+1. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Handshake rules:
  - A requester keeps addr/data stable and req high until it sees ready.
  - It drops req in the cycle after ready. A req still high in the next IDLE is treated as a new request.
  - Dropping req during ACCESS or RESP is ignored: the access completes and ready still pulses.
- Simultaneous requests: exactly one grant. The loser keeps its stall asserted and is served in the next IDLE.
- Ready pulses are mutually exclusive; if_ready and dm_ready are never both 1.
- Stall outputs are combinational from req and the registered ready.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - On a tie, grant the port not served last.
  - A pointer is updated on every grant.
  - A single requester always wins regardless of the pointer.
- Undefined:
  - Fixed priority: data (port 1) beats IF on a tie.
  - No pointer register exists.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - port IDs: PORT_IF=1'b0, PORT_DM=1'b1
  - the default WAIT_CYCLES constant
- One natural sub-module: arb_wait_counter, a loadable down-counter with a zero flag.
- The top instantiates the existing 32-bit 2:1 mux for address and write data, driven by mux_sel. The latching registers sit after the mux.

Test Plan:
- Reset: hold rst high 2 cycles with both reqs high -> all outputs 0 and state IDLE; rst low -> first mem_en one cycle later.
- Single IF read, WAIT_CYCLES=2: if_req, addr 0x100 at t0; memory returns 0xE3A01005 -> mem_en high t1..t2, mux_sel=0, if_ready and rdata=0xE3A01005 at t3, if_stall high t0..t2.
- Data store: dm_we=1, addr 0x400, wdata 0xDEADBEEF -> mem_we=1 during ACCESS, mem_addr=0x400, mem_wdata=0xDEADBEEF, dm_ready at t3, rdata not checked.
- Simultaneous requests, macro off: IF 0x104 and load 0x408 -> data served first (dm_ready t3); IF served next (if_ready t7).
- Simultaneous requests repeated, ARB_ROUND_ROBIN_EN defined: grants alternate IF/DM/IF/DM over 4 ties; a lone IF after an IF grant still wins.
- Reset mid-access: assert rst during the second ACCESS cycle -> no ready pulse, mem_en 0 next cycle; after release the same request completes with a correct rdata.
